digit_seq_checker: RTL and testbench
====================================

Name: digit_seq_checker

Overview:
- Consumer end of the 0–9 random digit stream: builds a growing memory-game sequence by appending one generator digit per round.
- Replays the stored sequence on a display interface, then checks user key entries against it digit by digit.
- Reports pass, fail or win.
- Sits between the random digit generator, the keypad debouncer and the 7-segment display driver.

Parameters:
- MAX_LEN, 8, maximum sequence length (1..15); reaching it and passing = win.
- SHOW_CYCLES, 4, cycles each digit is held on show_digit with show_valid=1.
- GAP_CYCLES, 2, blank cycles (show_valid=0) after each shown digit.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin next round; honoured only in IDLE
- rnd  in  4  digit from random generator, nominally 0–9
- key_valid  in  1  one-cycle strobe, user pressed a key
- key_digit  in  4  key value, valid with key_valid
- show_digit  out  4  digit being replayed; 0 when show_valid=0
- show_valid  out  1  show_digit is to be displayed
- await_key  out  1  high while in INPUT state
- busy  out  1  high whenever state != IDLE
- level  out  4  current sequence length
- pass  out  1  one-cycle pulse, round completed correctly
- fail  out  1  one-cycle pulse, wrong key
- win  out  1  one-cycle pulse, MAX_LEN round passed

Behaviour:
- Reset (synchronous, active-high): state=IDLE, level=0, idx=0, hold counter=0. All outputs 0. Buffer contents don't care.
- All outputs are registered.
- States: IDLE, SHOW_ON, SHOW_GAP, INPUT.
- IDLE + start:
  - At that edge, rnd is sampled into buf[level]. If rnd ≥10, rnd−10 is stored.
  - level increments; idx=0; go to SHOW_ON.
  - start in any other state is ignored.
- SHOW_ON:
  - show_valid=1, show_digit=buf[idx] for exactly SHOW_CYCLES cycles, then go to SHOW_GAP.
- SHOW_GAP:
  - show_valid=0, show_digit=0 for exactly GAP_CYCLES cycles.
  - If idx==level−1: go to INPUT with idx=0. Otherwise idx++ and return to SHOW_ON.
  - GAP_CYCLES=0 means SHOW_ON proceeds directly to the next digit or to INPUT.
- INPUT (await_key=1):
  - Each key_valid compares key_digit against buf[idx].
  - key_digit ≥10 always counts as a mismatch.
  - Mismatch: fail=1 next cycle; level←0; go to IDLE.
  - Match with idx<level−1: idx++, stay in INPUT.
  - Match with idx==level−1 and level<MAX_LEN: pass=1 next cycle; go to IDLE; level kept.
  - Match with idx==level−1 and level==MAX_LEN: pass=1 and win=1 in the same cycle; level←0; go to IDLE.
- key_valid outside INPUT is ignored, including keys pressed during replay.
- Pulses: pass/fail/win are high for exactly one cycle; they coincide with busy=0 in the first IDLE cycle.
- Latency: start edge → show_valid high on the next cycle. First shown digit is buf[0].
- start asserted in the same cycle a pulse is output is honoured: state is IDLE at that point.
- Reset mid-round (any state) aborts immediately: next cycle all outputs 0, level=0.
- Counter widths: level and idx are 4 bits. Hold counter must cover max(SHOW_CYCLES, GAP_CYCLES).
- No wrap of level beyond MAX_LEN is possible.

Test Plan:
- SHOW_CYCLES=2, GAP_CYCLES=1. Reset, then start with rnd=7 → next cycle show_valid=1, show_digit=7 for 2 cycles, then 1 gap cycle; await_key=1 on the following cycle; level=1.
- Correct entry: in INPUT, key_valid with key_digit=7 → pass=1 for one cycle, busy=0, level stays 1. Second start with rnd=3 → replay 7 then 3; keys 7,3 → pass, level=2.
- Wrong key: level=2, buffer {7,3}; keys 7 then 4 → fail pulse on the cycle after the second key; level=0, await_key=0.
- Out-of-range handling: start with rnd=12 → show_digit=2. In INPUT, key_digit=10 → fail.
- Ignored inputs: key_valid pulses during SHOW_ON/SHOW_GAP and start pulses during INPUT cause no state, idx or level change; correct keys afterwards still give pass.
- Win and abort:
  - MAX_LEN=3: three correct rounds → final key gives pass=1 and win=1 together, level=0.
  - Separately, assert reset during SHOW_ON at level=2 → next cycle show_valid=0, busy=0, level=0.

Source files
------------

// File: rtl/digit_seq_checker.sv
// digit_seq_checker: memory-game sequencer. Appends one generator digit per
// round, replays the stored sequence on the display interface, then checks
// keypad entries against it and reports pass / fail / win pulses.
module digit_seq_checker #(
    parameter int MAX_LEN     = 8,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rnd,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] show_digit,
    output logic       show_valid,
    output logic       await_key,
    output logic       busy,
    output logic [3:0] level,
    output logic       pass,
    output logic       fail,
    output logic       win
);

    // Hold counter spans the longer of the show and gap phases.
    localparam int HMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = (HMAX < 2) ? 1 : $clog2(HMAX);

    typedef enum logic [1:0] {IDLE, SHOW_ON, SHOW_GAP, INPUT} state_t;

    state_t        state, state_n;
    logic [3:0]    idx, idx_n, level_n;
    logic [CW-1:0] hold, hold_n;
    logic          pass_n, fail_n, win_n;
    logic          wr_en;
    logic [3:0]    wr_digit;
    logic [3:0]    show_n;
    logic          last;

    // Sized to the full 4-bit index space so level/idx address it directly.
    logic [3:0]    seq_mem [16];

    // Fold out-of-range generator values back into 0..9.
    always_comb wr_digit = (rnd >= 4'd10) ? (rnd - 4'd10) : rnd;

    // Current position is the final digit of the sequence.
    always_comb last = (idx == (level - 4'd1));

    // Next-state, counters and next output values.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        level_n = level;
        hold_n  = hold;
        pass_n  = 1'b0;
        fail_n  = 1'b0;
        win_n   = 1'b0;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    wr_en   = 1'b1;
                    level_n = level + 4'd1;
                    idx_n   = 4'd0;
                    hold_n  = '0;
                    state_n = SHOW_ON;
                end
            end
            SHOW_ON: begin
                if (hold == CW'(SHOW_CYCLES - 1)) begin
                    hold_n = '0;
                    if (GAP_CYCLES > 0) begin
                        state_n = SHOW_GAP;
                    end else if (last) begin
                        state_n = INPUT;
                        idx_n   = 4'd0;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end else begin
                    hold_n = hold + 1'b1;
                end
            end
            SHOW_GAP: begin
                if (hold == CW'(GAP_CYCLES - 1)) begin
                    hold_n = '0;
                    if (last) begin
                        state_n = INPUT;
                        idx_n   = 4'd0;
                    end else begin
                        state_n = SHOW_ON;
                        idx_n   = idx + 4'd1;
                    end
                end else begin
                    hold_n = hold + 1'b1;
                end
            end
            INPUT: begin
                if (key_valid) begin
                    if (key_digit >= 4'd10 || key_digit != seq_mem[idx]) begin
                        fail_n  = 1'b1;
                        level_n = 4'd0;
                        state_n = IDLE;
                    end else if (!last) begin
                        idx_n = idx + 4'd1;
                    end else begin
                        pass_n  = 1'b1;
                        state_n = IDLE;
                        if (level == 4'(MAX_LEN)) begin
                            win_n   = 1'b1;
                            level_n = 4'd0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Digit for the next display cycle; bypasses the buffer when the first
    // digit is being written on this same edge.
    always_comb begin
        show_n = 4'd0;
        if (state_n == SHOW_ON) begin
            if (wr_en && idx_n == level) show_n = wr_digit;
            else                         show_n = seq_mem[idx_n];
        end
    end

    // Sequence buffer write on round start; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) seq_mem[level] <= wr_digit;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            level      <= 4'd0;
            hold       <= '0;
            show_digit <= 4'd0;
            show_valid <= 1'b0;
            await_key  <= 1'b0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            win        <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            level      <= level_n;
            hold       <= hold_n;
            show_digit <= show_n;
            show_valid <= (state_n == SHOW_ON);
            await_key  <= (state_n == INPUT);
            busy       <= (state_n != IDLE);
            pass       <= pass_n;
            fail       <= fail_n;
            win        <= win_n;
        end
    end

endmodule

// File: tb/tb_digit_seq_checker.sv
// Bench for digit_seq_checker: directed rounds from the test plan followed by
// random traffic, all outputs compared every cycle against a timeline model.
module tb_digit_seq_checker;

    localparam int MAXL = 3;
    localparam int S    = 2;
    localparam int G    = 1;
    localparam int P    = S + G;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rnd = 4'd0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic [3:0] show_digit, level;
    logic       show_valid, await_key, busy, pass, fail, win;

    digit_seq_checker #(.MAX_LEN(MAXL), .SHOW_CYCLES(S), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .start(start), .rnd(rnd),
        .key_valid(key_valid), .key_digit(key_digit),
        .show_digit(show_digit), .show_valid(show_valid), .await_key(await_key),
        .busy(busy), .level(level), .pass(pass), .fail(fail), .win(win)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: phase 0 idle, 1 replay, 2 input. t = cycles since start edge.
    int         phase = 0;
    int         t = 0;
    int         kidx = 0;
    logic [3:0] seq[$];
    logic       ep = 0, ef = 0, ew = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic [3:0] r, input logic kv,
                              input logic [3:0] kd, input logic rs);
        ep = 0; ef = 0; ew = 0;
        if (rs) begin
            phase = 0;
            seq.delete();
        end else begin
            case (phase)
                0: if (st) begin
                    seq.push_back(4'(int'(r) % 10));
                    phase = 1;
                    t = 1;
                end
                1: begin
                    t++;
                    if (t > seq.size() * P) begin
                        phase = 2;
                        kidx = 0;
                    end
                end
                default: if (kv) begin
                    if (kd != seq[kidx]) begin
                        ef = 1;
                        seq.delete();
                        phase = 0;
                    end else if (kidx == seq.size() - 1) begin
                        ep = 1;
                        phase = 0;
                        if (seq.size() == MAXL) begin
                            ew = 1;
                            seq.delete();
                        end
                    end else begin
                        kidx++;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after.
    task automatic step(input logic st, input logic [3:0] r, input logic kv,
                        input logic [3:0] kd, input logic rs, input string tag);
        logic       sv;
        logic [3:0] sd;
        start = st; rnd = r; key_valid = kv; key_digit = kd; reset = rs;
        @(posedge clk);
        model_edge(st, r, kv, kd, rs);
        #1;
        sv = (phase == 1) && (((t - 1) % P) < S);
        sd = sv ? seq[(t - 1) / P] : 4'd0;
        chk(tag, {18'd0, show_digit, show_valid, await_key, busy, level, pass, fail, win},
                 {18'd0, sd, sv, phase == 2, phase != 0, 4'(seq.size()), ep, ef, ew});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, "idle");
    endtask

    task automatic wait_input(input logic stray);
        int n = 0;
        while (phase != 2 && n < 200) begin
            step(0, 0, stray, 4'($urandom_range(15)), 0, "replay");
            n++;
        end
        chk("wait_input", 32'(phase == 2), 32'd1);
    endtask

    task automatic key(input logic [3:0] d);
        step(0, 0, 1, d, 0, "key");
    endtask

    // Start a round, wait for input, enter the whole sequence correctly.
    task automatic round_ok(input logic [3:0] r, input logic stray);
        step(1, r, 0, 0, 0, "start");
        wait_input(stray);
        for (int i = 0; i < seq.size(); i++) begin
            if (stray) step(1, 4'($urandom_range(15)), 0, 0, 0, "stray_start");
            key(seq[i]);
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 1, "reset");
        // Basic round, then two-digit round.
        round_ok(4'd7, 0);
        idle(1);
        round_ok(4'd3, 0);
        idle(2);
        // Wrong second key.
        step(1, 4'd9, 0, 0, 0, "start");
        wait_input(0);
        key(4'd7);
        key(4'd4);
        idle(1);
        // Out-of-range generator digit and key.
        step(1, 4'd12, 0, 0, 0, "start12");
        wait_input(0);
        key(4'd10);
        idle(1);
        // Stray keys during replay and stray starts during input, then win.
        round_ok(4'd5, 1);
        round_ok(4'd15, 1);
        round_ok(4'd0, 0);
        idle(2);
        // Reset in SHOW_ON at level 2.
        round_ok(4'd8, 0);
        step(1, 4'd1, 0, 0, 0, "start");
        step(0, 0, 0, 0, 0, "show_on");
        step(0, 0, 0, 0, 1, "abort");
        idle(2);
        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic       st, kv, rs;
            logic [3:0] kd;
            st = ($urandom_range(3) == 0);
            rs = ($urandom_range(80) == 0);
            kv = ($urandom_range(2) == 0);
            kd = 4'($urandom_range(15));
            if (phase == 2 && $urandom_range(7) != 0) kd = seq[kidx];
            step(st, 4'($urandom_range(15)), kv, kd, rs, "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
